md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline. Consumes operands
//  and the MD op decoded from the ID_EX register outputs. Owns the HI/LO registers.
//  Runs multi-cycle mult/multu/div/divu operations and raises BUSY so the hazard unit can:
//  - stall IF_ID (IFID_EN=0);
//  - bubble ID_EX (IDEX_CLR=1) for any MD instruction behind it.
// PARAMETERS
//  MULT_CYCLES  5   BUSY duration for mult/multu, in cycles; legal range 1..15.
//  DIV_CYCLES   10  BUSY duration for div/divu, in cycles; legal range 1..15.
// PORTS
//  clk       in   1   pipeline clock; all state updates on posedge.
//  reset     in   1   asynchronous, active-low reset (0 = reset).
//  MD_START  in   1   MD instruction valid in EX this cycle; a single-cycle pulse.
//  MD_OP     in   3   000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
//                     Codes 110 and 111 are no-ops.
//  RS_IN     in   32  forwarded rs operand (multiplicand / dividend / mthi-mtlo data).
//  RT_IN     in   32  forwarded rt operand (multiplier / divisor).
//  BUSY      out  1   high while an operation is in flight.
//  HI_OUT    out  32  HI register; read combinationally by mfhi.
//  LO_OUT    out  32  LO register; read combinationally by mflo.
// BEHAVIOUR
//  Reset: while reset=0, asynchronously force the following, regardless of clk:
//   - state=IDLE, BUSY=0, HI_OUT=0, LO_OUT=0;
//   - counter=0, pending HI/LO=0.
//   Reset during RUN abandons the in-flight operation; HI/LO do not update.
//  States: IDLE, RUN.
//  IDLE with MD_START=1 on edge t0:
//   - mult/multu/div/divu:
//       * compute the 64-bit result into pending {HI,LO};
//       * load counter with N-1, where N = MULT_CYCLES or DIV_CYCLES;
//       * go to RUN; BUSY=1 from t0.
//   - mthi: HI_OUT<=RS_IN at t0; LO unchanged; stay IDLE; BUSY stays 0.
//   - mtlo: LO_OUT<=RS_IN at t0; HI unchanged; stay IDLE; BUSY stays 0.
//   - reserved op: nothing changes.
//  RUN, each edge:
//   - counter!=0: decrement.
//   - counter==0: HI_OUT/LO_OUT<=pending, BUSY<=0, go to IDLE.
//   - Net effect: BUSY is high for exactly N cycles after t0; the results are
//     visible in the cycle that follows.
//  MD_START while BUSY=1 (any op, including mthi/mtlo) is ignored.
//   - The hazard unit guarantees this does not occur.
//   - The ignore is still mandatory so a missed stall cannot corrupt HI/LO.
//  MD_START on the same edge that RUN completes: ignored; BUSY is still 1 in that cycle.
//  HI_OUT/LO_OUT hold their old values throughout RUN; mfhi/mflo are stalled by hazard logic.
//  Arithmetic:
//   - mult: signed 32x32 -> 64; HI = bits 63:32, LO = bits 31:0.
//   - multu: same as mult, but unsigned.
//   - div: signed. LO = quotient, truncated toward zero.
//     HI = remainder, which takes the sign of the dividend.
//   - divu: unsigned; LO = quotient, HI = remainder.
//   - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no trap.
//   - Divisor==0 (div or divu): BUSY still lasts DIV_CYCLES; HI/LO keep their prior values.
//  Operands are sampled only at t0; later changes to RS_IN/RT_IN do not affect the result.
// TESTING
//  1. Reset (reset=0), then release -> BUSY=0, HI=LO=0.
//     Then mthi 0x12345678 -> next cycle HI=0x12345678, LO=0, BUSY never high.
//  2. mult RS=0xFFFFFFFD (-3), RT=4 -> BUSY high 5 cycles.
//     Then HI=0xFFFFFFFF, LO=0xFFFFFFF4.
//  3. multu RS=RT=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
//  4. div -7/2 -> BUSY high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     divu 7/2 -> LO=3, HI=1.
//     div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  5. With HI=0xAA, LO=0xBB: divu by 0 -> BUSY high 10 cycles; HI=0xAA, LO=0xBB unchanged.
//  6. Hazard and reset cases:
//     - mult 2*3, then mtlo 0x55 while BUSY -> mtlo ignored; final LO=6, HI=0.
//     - Pull reset low on cycle 3 of a div -> BUSY=0, HI=LO=0 immediately.

Source files
------------

// File: rtl/md_unit_if.sv
// Handshake bundle between the EX stage and the multiply/divide unit.
// The EX stage issues ops; the unit reports BUSY and exposes HI/LO.
interface md_unit_if;
    logic        MD_START;
    logic [2:0]  MD_OP;
    logic [31:0] RS_IN;
    logic [31:0] RT_IN;
    logic        BUSY;
    logic [31:0] HI_OUT;
    logic [31:0] LO_OUT;

    modport master (
        output MD_START, MD_OP, RS_IN, RT_IN,
        input  BUSY, HI_OUT, LO_OUT
    );

    modport slave (
        input  MD_START, MD_OP, RS_IN, RT_IN,
        output BUSY, HI_OUT, LO_OUT
    );
endinterface

// File: rtl/md_unit.sv
// MIPS EX-stage multiply/divide unit owning HI/LO.
// Results are computed at issue and released after a fixed BUSY window.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic [31:0] rs, rt;
    logic [63:0] prod_signed, prod_unsigned;
    logic [31:0] rs_mag, rt_mag, rt_mag_safe, rt_safe;
    logic [31:0] quot_mag, rem_mag, quot_signed, rem_signed;
    logic [31:0] quot_unsigned, rem_unsigned;
    logic        rt_zero;

    assign rs = md.RS_IN;
    assign rt = md.RT_IN;

    // Signed division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // instead of overflowing; the zero-divisor guard keeps the dividers X-free.
    always_comb begin
        rt_zero       = (rt == 32'd0);
        prod_signed   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_unsigned = {32'd0, rs} * {32'd0, rt};
        rs_mag        = rs[31] ? (~rs + 32'd1) : rs;
        rt_mag        = rt[31] ? (~rt + 32'd1) : rt;
        rt_mag_safe   = rt_zero ? 32'd1 : rt_mag;
        rt_safe       = rt_zero ? 32'd1 : rt;
        quot_mag      = rs_mag / rt_mag_safe;
        rem_mag       = rs_mag % rt_mag_safe;
        quot_signed   = (rs[31] ^ rt[31]) ? (~quot_mag + 32'd1) : quot_mag;
        rem_signed    = rs[31] ? (~rem_mag + 32'd1) : rem_mag;
        quot_unsigned = rs / rt_safe;
        rem_unsigned  = rs % rt_safe;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (md.MD_START) begin
                    case (md.MD_OP)
                        3'b000: begin
                            {pend_hi_d, pend_lo_d} = prod_signed;
                            count_d = MULT_LOAD;
                            state_d = RUN;
                        end
                        3'b001: begin
                            {pend_hi_d, pend_lo_d} = prod_unsigned;
                            count_d = MULT_LOAD;
                            state_d = RUN;
                        end
                        3'b010: begin
                            // A zero divisor re-releases the current HI/LO unchanged.
                            {pend_hi_d, pend_lo_d} = rt_zero ? {hi_q, lo_q}
                                                             : {rem_signed, quot_signed};
                            count_d = DIV_LOAD;
                            state_d = RUN;
                        end
                        3'b011: begin
                            {pend_hi_d, pend_lo_d} = rt_zero ? {hi_q, lo_q}
                                                             : {rem_unsigned, quot_unsigned};
                            count_d = DIV_LOAD;
                            state_d = RUN;
                        end
                        3'b100:  hi_d = rs;
                        3'b101:  lo_d = rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Any MD_START seen here, including on the final edge, is dropped.
                if (count_q == 4'd0) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign md.BUSY   = (state_q == RUN);
    assign md.HI_OUT = hi_q;
    assign md.LO_OUT = lo_q;

endmodule
